// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// Optional saturation on overflow: define BCD_TO_BIN_SATURATE_EN.
module bcd_to_bin #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 8,
    parameter int CONV_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  ovf,
    output logic                  err_digit
);

    localparam int DW = 4 * DIGITS;
    localparam int CW = $clog2(CONV_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [DW-1:0]     d_q, d_d;
    logic [CONV_W-1:0] b_q, b_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;

    logic [BIN_W-1:0]  bin_q, bin_d;
    logic              ovf_q, ovf_d;
    logic              erro_q, erro_d;

    logic              in_err;
    logic              last_step;
    logic              enter_done;
    logic [DW+CONV_W-1:0] sh;
    logic [DW-1:0]     d_sh;
    logic [CONV_W-1:0] b_sh;
    logic [CONV_W-1:0] hi;
    logic              res_ovf;
    logic [BIN_W-1:0]  res_bin;

    always_comb begin
        in_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) in_err = 1'b1;
        end
    end

    assign last_step = (cnt_q == CW'(CONV_W));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; an invalid digit skips the shift phase entirely
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (err_q || last_step) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            IDLE:    busy = 1'b0;
            SHIFT:   busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    // One reverse double-dabble step: shift right, then fix digits >= 8
    always_comb begin
        sh   = {d_q, b_q} >> 1;
        d_sh = sh[DW+CONV_W-1:CONV_W];
        b_sh = sh[CONV_W-1:0];
        for (int i = 0; i < DIGITS; i++) begin
            if (d_sh[4*i +: 4] >= 4'd8) d_sh[4*i +: 4] = d_sh[4*i +: 4] - 4'd3;
        end
    end

    always_comb begin
        hi      = b_q >> BIN_W;
        res_ovf = |hi;
        res_bin = b_q[BIN_W-1:0];
`ifdef BCD_TO_BIN_SATURATE_EN
        if (res_ovf) res_bin = '1;
`else
        res_bin = b_q[BIN_W-1:0];
`endif
    end

    assign enter_done = (state_q != DONE) && (state_d == DONE);

    always_comb begin
        d_d    = d_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        bin_d  = bin_q;
        ovf_d  = ovf_q;
        erro_d = erro_q;
        if (state_q == IDLE && start) begin
            d_d   = bcd_in;
            b_d   = '0;
            cnt_d = '0;
            err_d = in_err;
        end else if (state_q == SHIFT && !err_q && !last_step) begin
            d_d   = d_sh;
            b_d   = b_sh;
            cnt_d = cnt_q + CW'(1);
        end
        if (enter_done) begin
            bin_d  = err_q ? '0 : res_bin;
            ovf_d  = err_q ? 1'b0 : res_ovf;
            erro_d = err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q    <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            bin_q  <= '0;
            ovf_q  <= 1'b0;
            erro_q <= 1'b0;
        end else begin
            d_q    <= d_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            bin_q  <= bin_d;
            ovf_q  <= ovf_d;
            erro_q <= erro_d;
        end
    end

    assign bin_out   = bin_q;
    assign ovf       = ovf_q;
    assign err_digit = erro_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed-vector testbench for bcd_to_bin.
// Expectations follow BCD_TO_BIN_SATURATE_EN when it is defined.
module tb_bcd_to_bin;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] bcd_in;
    logic        busy;
    logic        done;
    logic [7:0]  bin_out;
    logic        ovf;
    logic        err_digit;

    int n_cmp;
    int n_bad;

    bcd_to_bin dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bcd_in    (bcd_in),
        .busy      (busy),
        .done      (done),
        .bin_out   (bin_out),
        .ovf       (ovf),
        .err_digit (err_digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one conversion, scramble bcd_in, then wait for done
    task automatic run(input string tag, input logic [11:0] bcd,
                       input logic [7:0] eb, input logic eo,
                       input logic ee, input int lat);
        int n;
        @(negedge clk);
        bcd_in = bcd;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        bcd_in = 12'h3C5;
        chk({tag, "_busy0"}, busy, 1);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (!done) chk({tag, "_busy"}, busy, 1);
        end
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_bin"}, bin_out, eb);
        chk({tag, "_ovf"}, ovf, eo);
        chk({tag, "_err"}, err_digit, ee);
        chk({tag, "_bsyd"}, busy, 1);
        @(posedge clk);
        #1;
        chk({tag, "_done_clr"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_hold"}, bin_out, eb);
    endtask

    initial begin
        int ndone;
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        start  = 1'b0;
        bcd_in = 12'h000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bin", bin_out, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_err", err_digit, 0);
        rst = 1'b0;

        run("v255", 12'h255, 8'hFF, 0, 0, 11);
        run("v128", 12'h128, 8'h80, 0, 0, 11);
        run("v000", 12'h000, 8'h00, 0, 0, 11);
`ifdef BCD_TO_BIN_SATURATE_EN
        run("v999", 12'h999, 8'hFF, 1, 0, 11);
        run("v256", 12'h256, 8'hFF, 1, 0, 11);
`else
        run("v999", 12'h999, 8'hE7, 1, 0, 11);
        run("v256", 12'h256, 8'h00, 1, 0, 11);
`endif
        run("v1A3", 12'h1A3, 8'h00, 0, 1, 1);
        run("v042", 12'h042, 8'h2A, 0, 0, 11);

        // Start during conversion must be ignored
        @(negedge clk);
        bcd_in = 12'h100;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (2) @(negedge clk);
        bcd_in = 12'h077;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 12'h999;
        ndone  = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                chk("ign_bin", bin_out, 8'h64);
            end
        end
        chk("ign_ndone", ndone, 1);

        // Reset in the middle of a conversion aborts it
        @(negedge clk);
        bcd_in = 12'h200;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_bin", bin_out, 0);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_nodone", ndone, 0);
        run("v200", 12'h200, 8'hC8, 0, 0, 11);

        // Held start: back-to-back with one idle cycle between
        @(negedge clk);
        bcd_in = 12'h042;
        start  = 1'b1;
        ndone  = 0;
        while (!done && ndone < 40) begin
            @(negedge clk);
            ndone++;
        end
        chk("b2b_done", done, 1);
        @(negedge clk);
        chk("b2b_idle", busy, 0);
        @(negedge clk);
        chk("b2b_rearm", busy, 1);
        start = 1'b0;
        repeat (14) @(negedge clk);
        chk("b2b_bin", bin_out, 8'h2A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin.md
Name: bcd_to_bin

Overview:
- Sequential BCD-to-binary converter; the inverse of the display-side binary-to-BCD path.
- Accepts a packed multi-digit decimal number, for example three digits from switches or a keypad, and converts it to binary.
- Uses the iterative reverse double-dabble algorithm: shift right, then subtract 3 from each digit ≥ 8.
- Feeds byte-wide values into the key/plaintext load path of the AES top; start/busy/done handshake.

Parameters:
- DIGITS, 3, number of BCD digits accepted.
- BIN_W, 8, width of bin_out.
- CONV_W, 10, shift steps = width of full-range result; must satisfy 2^CONV_W > 10^DIGITS − 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request conversion; sampled only when busy=0.
- bcd_in  input  4*DIGITS  packed digits; [3:0]=units, [7:4]=tens, [11:8]=hundreds.
- busy  output  1  high from accepting edge through the done cycle.
- done  output  1  one-cycle pulse; result outputs valid.
- bin_out  output  BIN_W  converted value, held until next done.
- ovf  output  1  full-range value > 2^BIN_W − 1; held with bin_out.
- err_digit  output  1  some input digit > 9; held with bin_out.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, busy=0, done=0, bin_out=0, ovf=0, err_digit=0, step counter=0.
- Reset mid-conversion aborts: no done pulse, and all outputs go to their reset values.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 on an edge accepts the request: latch bcd_in into digit register D, clear binary register B (CONV_W bits), clear the step counter, busy=1.
  - If any latched digit > 9, go to DONE with an error result. Otherwise go to SHIFT.
- SHIFT, one step per edge:
  - Shift {D,B} right by 1.
  - Then, for each 4-bit digit of the shifted D: if ≥ 8, subtract 3.
  - All digit corrections happen in the same cycle.
  - After exactly CONV_W steps, go to DONE.
- DONE, one cycle:
  - done=1.
  - If no digit error: bin_out = B[BIN_W-1:0] (truncation); ovf=1 if B[CONV_W-1:BIN_W] ≠ 0; err_digit=0.
  - If digit error: bin_out=0, ovf=0, err_digit=1.
  - Next edge: IDLE, busy=0, done=0.
- Latency:
  - Valid input, accepted on edge k: done high in the cycle after edge k+CONV_W+1 (11 cycles for defaults).
  - Invalid digit: done high after edge k+1.
- Handshake rules:
  - start while busy=1, including the DONE cycle, is ignored. bcd_in changes after acceptance do not affect the result.
  - start held high continuously yields back-to-back conversions separated by one IDLE cycle.
- Width rules:
  - D is 4*DIGITS bits; the right shift fills D's MSB with 0, and D's LSB enters B's MSB.
  - After CONV_W steps D is all zero. Corrections never underflow, because a digit ≥ 8 only ever receives −3.
- ovf, err_digit and bin_out change only in the DONE cycle or on reset.

Optional Feature:
- Macro: BCD_TO_BIN_SATURATE_EN.
- Defined: on overflow, bin_out = all ones (2^BIN_W − 1), ovf=1.
- Undefined: on overflow, bin_out = low BIN_W bits of the value (modulo 2^BIN_W), ovf=1.
- Non-overflow and digit-error behaviour is identical in both builds.

Test Plan:
- bcd_in=12'h255, start pulse → done exactly 11 cycles after the accepting edge; bin_out=8'hFF, ovf=0, err_digit=0; busy high for those 11 cycles.
- bcd_in=12'h128 → bin_out=8'h80. bcd_in=12'h000 → bin_out=8'h00. Neither sets a flag.
- bcd_in=12'h999 → ovf=1. Without the macro bin_out=8'hE7; with BCD_TO_BIN_SATURATE_EN bin_out=8'hFF. bcd_in=12'h256 → ovf=1, bin_out 8'h00 / 8'hFF respectively.
- bcd_in=12'h1A3 (tens digit 0xA) → done 1 cycle after acceptance; err_digit=1, bin_out=0, ovf=0. A following start with 12'h042 → bin_out=8'h2A, err_digit=0.
- Start with 12'h100. Three cycles later, pulse start with 12'h077 and also change bcd_in → the second start is ignored; bin_out=8'h64 and only one done pulse.
- Start with 12'h200; assert rst at step 5 → no done, all outputs 0, busy=0. After release, start 12'h200 → bin_out=8'hC8 after 11 cycles.
